// File: rtl/aes_key_expansion_store_pkg.sv
// aes_key_expansion_store_pkg: shared constants, state encoding and GF(2^8) helpers for AES-128 key expansion
package aes_key_expansion_store_pkg;

    localparam int AES_ROUND_KEYS = 11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_t;

    // Indexed directly by the round counter; entry 0 and 11..15 are never used
    localparam logic [7:0] RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the S-box requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] s;
        logic [7:0] r;
        s = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

endpackage

// File: rtl/aes_key_expansion_store_sub_word.sv
// aes_sub_word: forward AES SubWord over four S-boxes (32-bit in, 32-bit out)
module aes_sub_word (
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);
    for (genvar g = 0; g < 4; g++) begin : g_sbox
        sbox_combi u_sbox (
            .en_or_de (1'b1),
            .data_in  (word_in[8*g +: 8]),
            .data_out (word_out[8*g +: 8])
        );
    end
endmodule

// sbox_combi: combinational AES S-box; en_or_de=1 forward, 0 inverse
module sbox_combi
    import aes_key_expansion_store_pkg::*;
(
    input  logic       en_or_de,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);
    logic [7:0] inv_fwd;
    logic [7:0] pre_inv;
    assign inv_fwd  = gf_inv(data_in);
    assign pre_inv  = rotl8(data_in, 1) ^ rotl8(data_in, 3) ^ rotl8(data_in, 6) ^ 8'h05;
    assign data_out = en_or_de
        ? inv_fwd ^ rotl8(inv_fwd, 1) ^ rotl8(inv_fwd, 2) ^ rotl8(inv_fwd, 3) ^ rotl8(inv_fwd, 4) ^ 8'h63
        : gf_inv(pre_inv);
endmodule

// File: rtl/aes_key_expansion_store.sv
// aes_key_expansion_store: iterative AES-128 key expansion into an 11-entry round-key file with indexed read
//   clk, reset_n (async active-low)
//   key_start_in/key_in : start pulse and cipher key ([127:96] = w0)
//   round_sel_in        : round key index 0..10, read with one-cycle latency
//   round_key_out       : selected round key, 0 when not ready or index out of range
//   key_ready_out       : all round keys valid; busy_out : expansion running
module aes_key_expansion_store
    import aes_key_expansion_store_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         key_start_in,
    input  logic [127:0] key_in,
    input  logic [3:0]   round_sel_in,
    output logic [127:0] round_key_out,
    output logic         key_ready_out,
    output logic         busy_out
);
    state_t       state, state_nxt;
    logic [3:0]   cnt, cnt_nxt;
    logic [127:0] keys [AES_ROUND_KEYS];
    logic [127:0] prev;
    logic [127:0] next_key;
    logic [31:0]  rot;
    logic [31:0]  sub;
    logic [31:0]  t;
    logic [31:0]  n0, n1, n2, n3;
    logic         accept;

    assign accept        = key_start_in && state != EXPAND;
    assign busy_out      = state == EXPAND;
    assign key_ready_out = state == READY;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (accept) begin
            state_nxt = EXPAND;
            cnt_nxt   = 4'd1;
        end else if (state == EXPAND) begin
            state_nxt = cnt == 4'(NUM_ROUNDS) ? READY : EXPAND;
            cnt_nxt   = cnt == 4'(NUM_ROUNDS) ? cnt : cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            round_key_out <= '0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            round_key_out <= (key_ready_out && round_sel_in <= 4'(NUM_ROUNDS)) ? keys[round_sel_in] : '0;
        end
    end

    // One round of the key schedule, always from the previously stored entry
    assign prev = keys[cnt - 4'd1];
    assign rot  = {prev[23:0], prev[31:24]};

    aes_sub_word u_sub_word (
        .word_in  (rot),
        .word_out (sub)
    );

    assign t        = sub ^ {RCON[cnt], 24'h0};
    assign n0       = prev[127:96] ^ t;
    assign n1       = prev[95:64] ^ n0;
    assign n2       = prev[63:32] ^ n1;
    assign n3       = prev[31:0] ^ n2;
    assign next_key = {n0, n1, n2, n3};

    // Contents need no reset: key_ready_out gates every read
    always_ff @(posedge clk) begin
        if (accept)
            keys[0] <= key_in;
        else if (state == EXPAND)
            keys[cnt] <= next_key;
    end
endmodule

// File: tb/tb_aes_key_expansion_store.sv
// tb_aes_key_expansion_store: directed, table-driven check of AES-128 key expansion and round-key reads
module tb_aes_key_expansion_store;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         key_start_in = 1'b0;
    logic [127:0] key_in = '0;
    logic [3:0]   round_sel_in = '0;
    logic [127:0] round_key_out;
    logic         key_ready_out;
    logic         busy_out;

    int tests = 0;
    int fails = 0;

    localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_B   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] A_R10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] B_R10   = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    typedef struct {
        logic [3:0]   sel;
        logic [127:0] exp;
    } vec_t;

    vec_t tbl [13];

    always #5 clk = ~clk;

    aes_key_expansion_store dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .key_start_in  (key_start_in),
        .key_in        (key_in),
        .round_sel_in  (round_sel_in),
        .round_key_out (round_key_out),
        .key_ready_out (key_ready_out),
        .busy_out      (busy_out)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic read_key(input logic [3:0] sel, input string name, input logic [127:0] exp);
        round_sel_in = sel;
        cycle();
        chk(name, round_key_out, exp);
    endtask

    // Start an expansion with k; optionally pulse a second start with k2 during EXPAND
    task automatic expand(input logic [127:0] k, input int inj, input logic [127:0] k2);
        key_in       = k;
        key_start_in = 1'b1;
        cycle();
        key_start_in = 1'b0;
        key_in       = k2;
        for (int i = 0; i < 10; i++) begin
            chk("busy_high", {127'd0, busy_out}, 128'd1);
            chk("ready_low", {127'd0, key_ready_out}, 128'd0);
            if (i > 0) chk("rk_not_ready", round_key_out, 128'd0);
            key_start_in = (i == inj);
            cycle();
            key_start_in = 1'b0;
        end
        chk("ready_high", {127'd0, key_ready_out}, 128'd1);
        chk("busy_low", {127'd0, busy_out}, 128'd0);
    endtask

    initial begin
        tbl[0]  = '{4'd10, A_R10};
        tbl[1]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
        tbl[2]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
        tbl[3]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        tbl[4]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        tbl[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        tbl[6]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
        tbl[7]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        tbl[8]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        tbl[9]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        tbl[10] = '{4'd0,  KEY_A};
        tbl[11] = '{4'd11, 128'd0};
        tbl[12] = '{4'd15, 128'd0};

        #1;
        chk("rst_rk", round_key_out, 128'd0);
        chk("rst_ready", {127'd0, key_ready_out}, 128'd0);
        chk("rst_busy", {127'd0, busy_out}, 128'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        cycle();

        expand(KEY_A, -1, KEY_B);
        read_key(4'd0, "a_r0", KEY_A);
        read_key(4'd1, "a_r1", tbl[9].exp);
        for (int i = 0; i < 13; i++) begin
            round_sel_in = tbl[i].sel;
            cycle();
            chk($sformatf("sweep_sel%0d", tbl[i].sel), round_key_out, tbl[i].exp);
        end

        expand(KEY_A, 4, KEY_B);
        read_key(4'd10, "ignored_start_r10", A_R10);
        read_key(4'd0, "ignored_start_r0", KEY_A);

        expand(KEY_B, -1, KEY_A);
        read_key(4'd10, "b_r10", B_R10);
        read_key(4'd0, "b_r0", KEY_B);

        key_in       = KEY_A;
        key_start_in = 1'b1;
        cycle();
        key_start_in = 1'b0;
        repeat (4) cycle();
        reset_n = 1'b0;
        #1;
        chk("abort_rk", round_key_out, 128'd0);
        chk("abort_ready", {127'd0, key_ready_out}, 128'd0);
        chk("abort_busy", {127'd0, busy_out}, 128'd0);
        @(negedge clk);
        reset_n = 1'b1;
        round_sel_in = 4'd10;
        for (int i = 0; i < 14; i++) begin
            cycle();
            chk("post_rst_ready", {127'd0, key_ready_out}, 128'd0);
            chk("post_rst_busy", {127'd0, busy_out}, 128'd0);
        end
        chk("post_rst_rk", round_key_out, 128'd0);

        expand(KEY_B, -1, KEY_B);
        read_key(4'd10, "recover_r10", B_R10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
